// File: rtl/clock_domain_exporter.sv
// Sending half of a two-phase req/ack toggle CDC handshake; holds each word stable until its ack returns.
// Optional burst FIFO enabled by defining CLOCK_DOMAIN_EXPORTER_FIFO_EN (default build: single word, ready = idle).
package clock_domain_exporter_pkg;
  localparam int CDE_BITS = 8;

  typedef struct packed {
    logic                req;
    logic [CDE_BITS-1:0] data;
  } iClockDomain_Exp;

  typedef struct packed {
    logic ack;
  } iClockDomain_Imp;
endpackage

module clock_domain_exporter
  import clock_domain_exporter_pkg::*;
#(
  parameter int pBits  = CDE_BITS,
  parameter int pDepth = 4
) (
  input  logic            clk,
  input  logic            rst,
  output iClockDomain_Exp cd_e,
  input  iClockDomain_Imp cd_i,
  input  logic            stb,
  input  logic [pBits-1:0] data,
  output logic            ready,
  output logic            drop
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [1:0]         ack_ff;
  logic               ack_s;
  logic               req_q;
  logic [pBits-1:0]   out_q;
  logic               drop_q;
  logic               launch;
  logic               avail;
  logic [pBits-1:0]   launch_data;

  if ((pDepth < 2) || ((pDepth & (pDepth - 1)) != 0)) begin : g_depth_check
    $error("pDepth must be a power of two >= 2");
  end

  assign ack_s = ack_ff[0];

`ifdef CLOCK_DOMAIN_EXPORTER_FIFO_EN
  localparam int AW = $clog2(pDepth);

  logic [pBits-1:0] mem [pDepth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push;

  // ready comes from the registered count only, so a same-cycle pop never frees a slot
  assign full        = (count == (AW+1)'(pDepth));
  assign ready       = !full;
  assign push        = stb && ready;
  assign avail       = (count != '0);
  assign launch_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  assign ready       = (state == S_IDLE);
  assign avail       = stb;
  assign launch_data = data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // IDLE ignores ack_s, so a one-sided reset parks here instead of chasing a stale ack
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_WAIT;
      S_WAIT:  if (ack_s == req_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    launch = 1'b0;
    if (state == S_IDLE) launch = avail;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_ff <= '0;
      req_q  <= 1'b0;
      out_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      ack_ff <= {cd_i.ack, ack_ff[1]};
      drop_q <= stb && !ready;
      if (launch) begin
        out_q <= launch_data;
        req_q <= ~req_q;
      end
    end
  end

  assign cd_e.req  = req_q;
  assign cd_e.data = out_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_clock_domain_exporter.sv
// Exporter driven against a behavioural importer on an unrelated clock; scoreboard of accepted vs received words.
module tb_clock_domain_exporter;
  import clock_domain_exporter_pkg::*;

  logic            clk = 1'b0;
  logic            rclk = 1'b0;
  logic            rst;
  logic            stb;
  logic [7:0]      data;
  logic            ready;
  logic            drop;
  iClockDomain_Exp cd_e;
  iClockDomain_Imp cd_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #10 clk = ~clk;
  always #13 rclk = ~rclk;

  clock_domain_exporter #(.pBits(8), .pDepth(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .cd_e  (cd_e),
    .cd_i  (cd_i),
    .stb   (stb),
    .data  (data),
    .ready (ready),
    .drop  (drop)
  );

  // Importer model: 2FF on req, capture on toggle, registered ack toggle
  logic [1:0] rreq_ff;
  logic       rack;
  always @(posedge rclk) begin
    if (rst) begin
      rreq_ff <= 2'b00;
      rack    <= 1'b0;
    end else begin
      rreq_ff <= {cd_e.req, rreq_ff[1]};
      if (rreq_ff[0] != rack) begin
        rack <= rreq_ff[0];
        rx_q.push_back(cd_e.data);
      end
    end
  end
  assign cd_i = '{ack: rack};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // data may only move together with a req toggle
  logic       prev_req = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_dat = 8'h00;
  always @(negedge clk) begin
    if (!rst && !prev_rst && (cd_e.data !== prev_dat))
      chk("data_stable", 32'(cd_e.req != prev_req), 32'(1));
    prev_req = cd_e.req;
    prev_dat = cd_e.data;
    prev_rst = rst;
  end

  // caller is at a negedge; drives one strobe cycle and records acceptance
  task automatic drive(input logic [7:0] d, output logic acc);
    acc  = ready;
    data = d;
    stb  = 1'b1;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1 stb = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d, output logic acc);
    @(negedge clk);
    drive(d, acc);
  endtask

  task automatic send(input logic [7:0] d, output logic acc);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'(1));
    drive(d, acc);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
      while (rx_q.size() != 0 && exp_q.size() != 0)
        chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    repeat (40) @(negedge clk);
    chk({tag, "_missing"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_extra"}, 32'(rx_q.size()), 32'(0));
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    logic acc;
`ifdef CLOCK_DOMAIN_EXPORTER_FIFO_EN
    logic [5:0] exp_acc = 6'b011111;
`endif
    rst  = 1'b1;
    stb  = 1'b0;
    data = 8'h00;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req", 32'(cd_e.req), 32'(0));
    chk("rst_data", 32'(cd_e.data), 32'(0));
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_drop", 32'(drop), 32'(0));

    // single word
    strobe(8'hA5, acc);
    chk("a5_acc", 32'(acc), 32'(1));
    @(negedge clk);
`ifdef CLOCK_DOMAIN_EXPORTER_FIFO_EN
    chk("a5_req_c1", 32'(cd_e.req), 32'(0));
    @(negedge clk);
`endif
    chk("a5_req", 32'(cd_e.req), 32'(1));
    chk("a5_data", 32'(cd_e.data), 32'(8'hA5));
`ifndef CLOCK_DOMAIN_EXPORTER_FIFO_EN
    chk("a5_busy", 32'(ready), 32'(0));
`endif
    drain("a5_rx");
    chk("a5_ready_back", 32'(ready), 32'(1));

`ifndef CLOCK_DOMAIN_EXPORTER_FIFO_EN
    // refusal while a word is in flight
    strobe(8'h11, acc);
    chk("busy_acc11", 32'(acc), 32'(1));
    strobe(8'h22, acc);
    chk("busy_acc22", 32'(acc), 32'(0));
    @(negedge clk);
    chk("busy_drop", 32'(drop), 32'(1));
    @(negedge clk);
    chk("busy_drop_end", 32'(drop), 32'(0));
    drain("busy_rx");
`else
    // burst: first word pops immediately, four more fill the FIFO, sixth drops
    for (int i = 0; i < 6; i++) begin
      strobe(8'(i + 1), acc);
      chk("burst_acc", 32'(acc), 32'(exp_acc[i]));
    end
    @(negedge clk);
    chk("burst_drop", 32'(drop), 32'(1));
    chk("burst_full", 32'(ready), 32'(0));
    @(negedge clk);
    chk("burst_drop_end", 32'(drop), 32'(0));
    drain("burst_rx");
`endif

    // spaced words, enough to wrap the FIFO pointers
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h30 + i), acc);
      chk("wrap_acc", 32'(acc), 32'(1));
      repeat (3) @(posedge clk);
    end
    drain("wrap_rx");

    // reset while a word is in flight
    send(8'h77, acc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
    @(negedge clk);
    chk("mid_rst_req", 32'(cd_e.req), 32'(0));
    chk("mid_rst_data", 32'(cd_e.data), 32'(0));
    chk("mid_rst_ready", 32'(ready), 32'(1));
    send(8'h5A, acc);
    chk("post_rst_acc", 32'(acc), 32'(1));
    drain("post_rst_rx");

    // random words with random gaps, some strobes blind to ready
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 9) < 3) strobe(8'($urandom), acc);
      else                          send(8'($urandom), acc);
    end
    drain("rand_rx");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
